// File: rtl/mask_downsampler_pkg.sv
// rtl/mask_downsampler_pkg.sv - shared frame geometry and downsampler state type
package mask_downsampler_pkg;

    localparam int CFG_IN_WIDTH   = 1280;
    localparam int CFG_IN_HEIGHT  = 720;
    localparam int CFG_FACTOR     = 4;
    localparam int CFG_OUT_WIDTH  = CFG_IN_WIDTH / CFG_FACTOR;
    localparam int CFG_OUT_HEIGHT = CFG_IN_HEIGHT / CFG_FACTOR;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACCUM      = 1'b1
    } ds_state_e;

endpackage

// File: rtl/mask_downsampler.sv
// rtl/mask_downsampler.sv - FACTOR x FACTOR block vote of a binary mask stream
// Emits one registered output per completed block, one cycle after its last pixel.
module mask_downsampler
    import mask_downsampler_pkg::*;
#(
    parameter int IN_WIDTH  = CFG_IN_WIDTH,
    parameter int IN_HEIGHT = CFG_IN_HEIGHT,
    parameter int FACTOR    = CFG_FACTOR,
    parameter int THRESHOLD = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        mask_in,
    input  logic        valid_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        mask_out,
    output logic        valid_out,
    output logic        new_frame_out
);

    localparam int OUT_W  = IN_WIDTH / FACTOR;
    localparam int LOG2F  = $clog2(FACTOR);
    localparam int COL_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ACC_W  = $clog2(FACTOR * FACTOR + 1);
    localparam int PART_W = LOG2F;

    ds_state_e          state_q, state_d;
    logic               in_range, frame_start, accepting, emit;
    logic               blk_end, row_end;
    logic [COL_W-1:0]   col_idx;
    logic [PART_W-1:0]  partial_q, partial_d, partial_base;
    logic [ACC_W-1:0]   col_base, total;
    logic [ACC_W-1:0]   col_acc_q [OUT_W];
    logic               valid_q, new_frame_q, mask_q;
    logic [10:0]        x_q;
    logic [9:0]         y_q;

    always_comb begin
        in_range    = valid_in && (int'(hcount_in) < IN_WIDTH) && (int'(vcount_in) < IN_HEIGHT);
        frame_start = in_range && (hcount_in == 11'd0) && (vcount_in == 10'd0);
        blk_end     = hcount_in[LOG2F-1:0] == LOG2F'(FACTOR - 1);
        row_end     = vcount_in[LOG2F-1:0] == LOG2F'(FACTOR - 1);
        col_idx     = COL_W'(hcount_in >> LOG2F);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= WAIT_FRAME;
        end else begin
            state_q <= state_d;
        end
    end

    // A (0,0) pixel restarts the frame from any state.
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = ACCUM;
        end
    end

    always_comb begin
        accepting = in_range && ((state_q == ACCUM) || frame_start);
        emit      = accepting && blk_end && row_end;
    end

    // Frame start zeroes the sums seen by its own pixel, so a restart leaves no residue.
    always_comb begin
        partial_base = frame_start ? '0 : partial_q;
        col_base     = frame_start ? '0 : col_acc_q[col_idx];
        total        = col_base + ACC_W'(partial_base) + ACC_W'(mask_in);
        partial_d    = partial_q;
        if (accepting) begin
            partial_d = blk_end ? '0 : partial_base + PART_W'(mask_in);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            partial_q   <= '0;
            for (int i = 0; i < OUT_W; i++) begin
                col_acc_q[i] <= '0;
            end
            valid_q     <= 1'b0;
            new_frame_q <= 1'b0;
            mask_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            partial_q <= partial_d;
            if (frame_start) begin
                for (int i = 0; i < OUT_W; i++) begin
                    col_acc_q[i] <= '0;
                end
            end
            if (accepting && blk_end) begin
                col_acc_q[col_idx] <= row_end ? '0 : total;
            end
            valid_q     <= emit;
            new_frame_q <= frame_start;
            if (emit) begin
                x_q    <= hcount_in >> LOG2F;
                y_q    <= vcount_in >> LOG2F;
                mask_q <= int'(total) >= THRESHOLD;
            end
        end
    end

    assign x_out         = x_q;
    assign y_out         = y_q;
    assign mask_out      = mask_q;
    assign valid_out     = valid_q;
    assign new_frame_out = new_frame_q;

endmodule

// File: tb/tb_mask_downsampler.sv
// tb/tb_mask_downsampler.sv - self-checking bench for mask_downsampler on a 32x16 frame
module tb_mask_downsampler;

    localparam int W = 32;
    localparam int H = 16;
    localparam int F = 4;
    localparam int T = 8;
    localparam int NOUT = (W / F) * (H / F);

    bit          clk;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        mask_in, valid_in;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        mask_out, valid_out, new_frame_out;

    mask_downsampler #(
        .IN_WIDTH (W),
        .IN_HEIGHT(H),
        .FACTOR   (F),
        .THRESHOLD(T)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst_in),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .mask_in      (mask_in),
        .valid_in     (valid_in),
        .x_out        (x_out),
        .y_out        (y_out),
        .mask_out     (mask_out),
        .valid_out    (valid_out),
        .new_frame_out(new_frame_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    // Model: image of pixels accepted in the current frame; a block's vote is its pixel sum.
    logic img [H][W];
    bit   active = 0;
    int   mdl_ones = 0;
    bit   exp_valid, exp_nf, exp_rst, exp_mask;
    int   exp_x, exp_y;

    int out_cnt, ones_cnt, nf_cnt, last_x, last_y;
    int in33_cyc, in73_cyc, o00_cyc, o10_cyc;
    bit o00_mask, o10_mask;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        out_cnt = 0; ones_cnt = 0; nf_cnt = 0; last_x = -1; last_y = -1; mdl_ones = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_out", int'(valid_out), int'(exp_valid));
            check("new_frame_out", int'(new_frame_out), int'(exp_nf));
            if (exp_valid) begin
                check("x_out", int'(x_out), exp_x);
                check("y_out", int'(y_out), exp_y);
                check("mask_out", int'(mask_out), int'(exp_mask));
            end
            if (exp_rst) begin
                check("reset_x", int'(x_out), 0);
                check("reset_y", int'(y_out), 0);
                check("reset_mask", int'(mask_out), 0);
            end
            if (valid_out) begin
                out_cnt++;
                if (mask_out) ones_cnt++;
                last_x = int'(x_out);
                last_y = int'(y_out);
                if (x_out == 0 && y_out == 0) begin o00_cyc = cyc; o00_mask = mask_out; end
                if (x_out == 1 && y_out == 0) begin o10_cyc = cyc; o10_mask = mask_out; end
            end
            if (new_frame_out) nf_cnt++;
        end
    end

    function automatic logic pat(input int sel, input int h, input int v);
        int idx;
        idx = (v % F) * F + (h % F);
        case (sel)
            0: return 1'b0;
            1: return 1'b1;
            default: begin
                if (v < F && h < F)          return idx < 8;
                else if (v < F && h < 2 * F) return idx < 7;
                else                         return ((h * 7 + v * 13) % 5) < 2;
            end
        endcase
    endfunction

    task automatic drive(input bit v, input int h, input int vv, input logic m);
        bit in_rng, nv, nnf;
        int s, nx, ny;
        valid_in  = v;
        hcount_in = 11'(h);
        vcount_in = 10'(vv);
        mask_in   = m;
        in_rng = v && h < W && vv < H;
        nnf = in_rng && h == 0 && vv == 0;
        nv  = 0; nx = 0; ny = 0; s = 0;
        if (nnf) begin
            active = 1;
            foreach (img[a, b]) img[a][b] = 1'b0;
        end
        if (in_rng && active) begin
            img[vv][h] = m;
            if (h % F == F - 1 && vv % F == F - 1) begin
                nx = h / F;
                ny = vv / F;
                for (int dy = 0; dy < F; dy++)
                    for (int dx = 0; dx < F; dx++)
                        s += int'(img[ny * F + dy][nx * F + dx]);
                nv = 1;
            end
        end
        if (v && h == 3 && vv == 3) in33_cyc = cyc;
        if (v && h == 7 && vv == 3) in73_cyc = cyc;
        @(posedge clk);
        #1;
        cyc++;
        exp_valid = nv;
        exp_nf    = nnf;
        exp_rst   = 0;
        if (nv) begin
            exp_x = nx; exp_y = ny; exp_mask = (s >= T);
            if (s >= T) mdl_ones++;
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst_in = 1'b0; valid_in = 1'b1; hcount_in = '0; vcount_in = '0; mask_in = 1'b1;
            active = 0;
            @(posedge clk);
            #1;
            cyc++;
            exp_valid = 0; exp_nf = 0; exp_rst = 1;
        end
        rst_in = 1'b1;
        valid_in = 1'b0;
    endtask

    task automatic run_frame(input int sel, input bit gaps, input int v_start, input int stop_px);
        int n;
        n = 0;
        for (int v = v_start; v < H; v++) begin
            for (int h = 0; h < W; h++) begin
                if (n == stop_px) return;
                if (sel == 0 && v == 2 && h == 0) begin
                    for (int k = 0; k < 10; k++) drive(1, 39, 1, 1'b1);
                    drive(1, 1300, 1, 1'b1);
                    drive(1, 3, 730, 1'b1);
                    drive(1, 35, 3, 1'b1);
                    drive(1, 3, 19, 1'b1);
                end
                if (gaps) while ($urandom_range(0, 1) == 1) drive(0, 0, 0, 1'b1);
                drive(1, h, v, pat(sel, h, v));
                n++;
            end
        end
    endtask

    initial begin
        rst_in = 1'b0; valid_in = 1'b0; hcount_in = '0; vcount_in = '0; mask_in = 1'b0;
        do_reset(3);
        chk_en = 1;

        // Pixels before any frame start must not produce output.
        clear_stats();
        drive(1, 3, 3, 1'b1);
        drive(1, 7, 3, 1'b1);
        drive(0, 0, 0, 1'b1);
        check("wait_frame_outputs", out_cnt, 0);

        clear_stats();
        run_frame(1, 0, 0, -1);
        drive(0, 0, 0, 1'b0);
        check("ones_count", out_cnt, NOUT);
        check("ones_set", ones_cnt, NOUT);
        check("ones_last_x", last_x, 7);
        check("ones_last_y", last_y, 3);
        check("ones_nf", nf_cnt, 1);

        clear_stats();
        run_frame(2, 0, 0, -1);
        drive(0, 0, 0, 1'b0);
        check("dir_mask00", int'(o00_mask), 1);
        check("dir_mask10", int'(o10_mask), 0);
        check("dir_lat00", o00_cyc, in33_cyc + 1);
        check("dir_lat10", o10_cyc, in73_cyc + 1);
        check("dir_count", out_cnt, NOUT);
        check("dir_ones", ones_cnt, mdl_ones);

        clear_stats();
        run_frame(2, 1, 0, -1);
        drive(0, 0, 0, 1'b0);
        check("gap_count", out_cnt, NOUT);
        check("gap_ones", ones_cnt, mdl_ones);
        check("gap_mask00", int'(o00_mask), 1);
        check("gap_mask10", int'(o10_mask), 0);

        clear_stats();
        run_frame(1, 0, 0, W * 2 + W / 2);
        run_frame(0, 0, 0, -1);
        drive(0, 0, 0, 1'b0);
        check("restart_nf", nf_cnt, 2);
        check("restart_count", out_cnt, NOUT);
        check("restart_ones", ones_cnt, 0);

        run_frame(1, 0, 0, 9 * W);
        clear_stats();
        do_reset(1);
        run_frame(1, 0, 9, -1);
        check("post_reset_outputs", out_cnt, 0);
        check("post_reset_nf", nf_cnt, 0);

        clear_stats();
        run_frame(1, 0, 0, -1);
        drive(0, 0, 0, 1'b0);
        check("after_reset_count", out_cnt, NOUT);
        check("after_reset_ones", ones_cnt, NOUT);
        check("after_reset_nf", nf_cnt, 1);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
